// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues ROM reads and buffers
// {pc, word} pairs in a small FIFO that feeds decode through a valid/ready handshake.
module fetch_queue #(
    parameter int unsigned            ADDR_W   = 12,
    parameter int unsigned            DEPTH    = 4,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      nRst,
    output logic [ADDR_W-1:0]         imemAddr,
    output logic                      imemEn,
    input  logic [31:0]               imemData,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirectPc,
    output logic                      instrValid,
    input  logic                      instrReady,
    output logic [31:0]               instrOut,
    output logic [ADDR_W-1:0]         instrPc,
    output logic [$clog2(DEPTH):0]    fifoLevel
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [31:0]       word_mem [DEPTH];

    logic push, pop, empty;

    // Credit counts the in-flight word as occupied, so the FIFO can never overflow.
    assign imemEn     = nRst && !redirect &&
                        ((count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
    assign imemAddr   = fetch_pc_q;
    assign empty      = (count_q == '0);
    assign instrValid = !empty && !redirect;
    assign push       = inflight_q && !redirect;
    assign pop        = instrValid && instrReady;
    assign instrOut   = empty ? '0 : word_mem[rd_ptr_q];
    assign instrPc    = empty ? '0 : pc_mem[rd_ptr_q];
    assign fifoLevel  = count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = imemEn;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (redirect) begin
            // Flush everything, including the word the ROM returns this cycle.
            fetch_pc_d = redirectPc;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (imemEn) begin
                fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
                inflight_pc_d = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage carries no reset; entries are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
            word_mem[wr_ptr_q] <= imemData;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: ROM model returns 0xA000_0000+addr; a queue of expected
// PCs is loaded on reset release / redirect and checked on every handshake.
module tb_fetch_queue;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              nRst;
    logic [ADDR_W-1:0] imemAddr;
    logic              imemEn;
    logic [31:0]       imemData = '0;
    logic              redirect;
    logic [ADDR_W-1:0] redirectPc;
    logic              instrValid;
    logic              instrReady;
    logic [31:0]       instrOut;
    logic [ADDR_W-1:0] instrPc;
    logic [2:0]        fifoLevel;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pop  = 0;
    int base;
    logic [ADDR_W-1:0] exp_q[$];

    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(12'h000)) dut (
        .clk(clk), .nRst(nRst), .imemAddr(imemAddr), .imemEn(imemEn),
        .imemData(imemData), .redirect(redirect), .redirectPc(redirectPc),
        .instrValid(instrValid), .instrReady(instrReady), .instrOut(instrOut),
        .instrPc(instrPc), .fifoLevel(fifoLevel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imemEn) imemData <= 32'hA000_0000 + {20'h0, imemAddr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic load_exp(input logic [ADDR_W-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + ADDR_W'(i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A handshake seen mid-cycle is taken at the next rising edge.
    always @(negedge clk) begin
        if (nRst && instrValid && instrReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'd1, 32'd0);
            end else begin
                logic [ADDR_W-1:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", 32'(instrPc), 32'(e));
                chk("pop_word", instrOut, 32'hA000_0000 + {20'h0, e});
            end
            n_pop++;
        end
    end

    initial begin
        nRst = 1'b0; redirect = 1'b0; redirectPc = '0; instrReady = 1'b0;
        #1;
        chk("rst_valid", 32'(instrValid), 0);
        chk("rst_en", 32'(imemEn), 0);
        chk("rst_level", 32'(fifoLevel), 0);
        chk("rst_out", instrOut, 0);
        chk("rst_pc", 32'(instrPc), 0);

        // Streaming with ready held high
        step(); step();
        nRst = 1'b1; instrReady = 1'b1; load_exp(12'h000);
        step();
        #1 chk("t1_valid_e1", 32'(instrValid), 0);
        step();
        #1 chk("t1_valid_e2", 32'(instrValid), 1);
        chk("t1_first_pc", 32'(instrPc), 0);
        chk("t1_first_word", instrOut, 32'hA000_0000);
        for (int i = 0; i < 10; i++) begin
            step();
            #1 chk("t1_nogap", 32'(instrValid), 1);
        end

        // Back-pressure fill then drain
        nRst = 1'b0; instrReady = 1'b0;
        #1 chk("t2_rst_level", 32'(fifoLevel), 0);
        step();
        nRst = 1'b1; load_exp(12'h000);
        repeat (10) step();
        #1 chk("t2_level_full", 32'(fifoLevel), DEPTH);
        chk("t2_en_low", 32'(imemEn), 0);
        chk("t2_addr_hold", 32'(imemAddr), 4);
        instrReady = 1'b1; base = n_pop;
        repeat (8) step();
        #1 chk("t2_drained", 32'(n_pop - base), 8);

        // Redirect while the FIFO holds stale entries
        instrReady = 1'b0;
        step(); step();
        redirect = 1'b1; redirectPc = 12'h100; load_exp(12'h100);
        #1 chk("t3_valid_redir", 32'(instrValid), 0);
        chk("t3_en_redir", 32'(imemEn), 0);
        step();
        redirect = 1'b0; instrReady = 1'b1;
        #1 chk("t3_addr", 32'(imemAddr), 32'h100);
        chk("t3_level", 32'(fifoLevel), 0);
        step();
        #1 chk("t3_valid_e1", 32'(instrValid), 0);
        step();
        #1 chk("t3_valid_e2", 32'(instrValid), 1);
        chk("t3_pc", 32'(instrPc), 32'h100);
        chk("t3_word", instrOut, 32'hA000_0100);
        repeat (3) step();

        // Redirect colliding with a handshake, target near the top of the address space
        redirect = 1'b1; redirectPc = 12'hFFE; load_exp(12'hFFE); base = n_pop;
        #1 chk("t4_valid_forced", 32'(instrValid), 0);
        step();
        redirect = 1'b0;
        #1 chk("t4_level", 32'(fifoLevel), 0);
        chk("t4_no_pop", 32'(n_pop - base), 0);
        step();
        step();
        #1 chk("t5_pc0", 32'(instrPc), 32'hFFE);
        step();
        #1 chk("t5_pc1", 32'(instrPc), 32'hFFF);
        step();
        #1 chk("t5_pc2", 32'(instrPc), 32'h000);
        step();
        #1 chk("t5_pc3", 32'(instrPc), 32'h001);

        // Asynchronous reset while full
        instrReady = 1'b0;
        repeat (8) step();
        #1 chk("t6_full", 32'(fifoLevel), DEPTH);
        #2 nRst = 1'b0; exp_q.delete();
        #1 chk("t6_valid_async", 32'(instrValid), 0);
        chk("t6_level_async", 32'(fifoLevel), 0);
        chk("t6_en_async", 32'(imemEn), 0);
        step(); step();
        nRst = 1'b1; instrReady = 1'b1; load_exp(12'h000);
        step(); step();
        #1 chk("t6_valid", 32'(instrValid), 1);
        chk("t6_first_pc", 32'(instrPc), 0);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
